zero_count_normalizer: RTL
==========================

Name: zero_count_normalizer

Overview:
- Two-stage pipelined normalizer that sits directly downstream of the leading/trailing zero counter in the ALU datapath.
- Stage 1 registers the operand together with its leading- or trailing-zero count.
- Stage 2 shifts the operand so its first set bit is at the MSB (leading mode) or at the LSB (trailing mode).
- Feeds the FP-normalize and bit-scan paths through a valid/ready handshake with full backpressure.

Parameters:
- WIDTH, 32, operand width; must be a power of two, minimum 8.
- CNT_W, derived localparam = clog2(WIDTH)+1 (6 at default); not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream offers an operand.
- in_ready  output  1  block accepts the operand this cycle.
- in_data  input  WIDTH  operand.
- in_mode  input  1  1 = leading-zero normalize, 0 = trailing-zero normalize.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  normalized operand.
- out_count  output  CNT_W  zero count; equals WIDTH when the operand is zero.
- out_zero  output  1  operand was all zeros.
- out_mode  output  1  in_mode carried through with the result.

Behaviour:
- Reset (rst_n=0 sampled at a clock edge): both stage valid bits cleared; out_valid=0, out_data=0, out_count=0, out_zero=0, out_mode=0.
  - Reset mid-operation discards all in-flight operands; no partial result is ever presented.
  - in_ready=0 while rst_n=0.
- Handshake:
  - Input transfer when in_valid and in_ready are both high at a clock edge.
  - Output transfer when out_valid and out_ready are both high at a clock edge.
  - out_valid and all out_* fields are held stable until the output transfer occurs.
- Stage 1 (count):
  - Count is computed combinationally from in_data and in_mode, using leading zeros from MSB or trailing zeros from LSB.
  - Zero operand gives count=WIDTH.
  - On accept, s1 registers data, mode, count, and zero flag.
- Stage 2 (shift):
  - Leading mode: data << count. Trailing mode: data >> count (logical).
  - Zero operand: out_data=0, out_zero=1, out_count=WIDTH; no shift is applied.
  - Count is never larger than WIDTH-1 for a nonzero operand, so no shift overflows.
- Latency: 2 cycles from input accept to out_valid with out_ready held high. Throughput: 1 operand per cycle.
- Stall rules:
  - s2 loads when s2 is empty or an output transfer occurs in the same cycle.
  - s1 advances into s2 under the same condition.
  - in_ready = !s1_valid || s1 advances this cycle (combinational; no path from in_valid to in_ready).
  - With out_ready=0 and both stages full: in_ready=0 and all stage contents hold.
- Simultaneous events:
  - Output transfer, s1→s2 move, and new input accept can all occur in one cycle with no bubble and no loss.
  - in_valid with in_ready=0: operand not taken; upstream must hold it.
- No combinational path from in_* to out_*.

Test Plan:
- Leading, data=0x0000_1000, out_ready=1 → 2 cycles later: out_valid=1, out_count=19, out_data=0x8000_0000, out_zero=0, out_mode=1.
- Trailing, data=0x0000_1000 → out_count=12, out_data=0x0000_0001, out_zero=0, out_mode=0.
- data=0, both modes → out_count=32, out_data=0, out_zero=1. Also data=0x8000_0000 leading → count=0, data unchanged; data=0x0000_0001 trailing → count=0, data unchanged.
- Back-to-back stream of 8 operands with out_ready=1 → in_ready stays 1; results appear in order, one per cycle, starting cycle 2.
- Backpressure: out_ready=0 for 5 cycles while feeding 3 operands → in_ready drops after 2 accepts; out fields stay stable; release out_ready → all 3 results in order, none lost or duplicated.
- Assert rst_n=0 for 1 cycle with both stages full → next cycle out_valid=0 and in_ready=1; no stale result is emitted afterwards.

Source files
------------

// File: rtl/zero_count_normalizer.sv
// Two-stage valid/ready normalizer: stage 1 registers the operand with its
// leading/trailing zero count, stage 2 shifts the first set bit to MSB or LSB.
module zero_count_normalizer #(
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero,
  output logic             out_mode
);

  if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
    $error("zero_count_normalizer: WIDTH must be a power of two >= 8");
  end

  logic [CNT_W-1:0] lead_cnt;
  logic [CNT_W-1:0] trail_cnt;
  logic             trail_found;
  logic [CNT_W-1:0] in_count;
  logic             in_zero;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_mode;
  logic [CNT_W-1:0] s1_count;
  logic             s1_zero;

  logic             s2_load;
  logic             s1_advance;
  logic             in_accept;
  logic [WIDTH-1:0] shifted;

  // Leading count: the highest set bit wins, so a plain ascending overwrite
  // works. Trailing count: the first set bit seen from the LSB is kept.
  always_comb begin
    lead_cnt    = CNT_W'(WIDTH);
    trail_cnt   = CNT_W'(WIDTH);
    trail_found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (in_data[i]) begin
        lead_cnt = CNT_W'(WIDTH - 1 - i);
        if (!trail_found) begin
          trail_cnt   = CNT_W'(i);
          trail_found = 1'b1;
        end
      end
    end
    in_zero  = (in_data == '0);
    in_count = in_mode ? lead_cnt : trail_cnt;
  end

  always_comb begin
    s2_load    = !out_valid || out_ready;
    s1_advance = s1_valid && s2_load;
    in_ready   = rst_n && (!s1_valid || s2_load);
    in_accept  = in_valid && in_ready;
  end

  always_comb begin
    shifted = '0;
    if (!s1_zero) begin
      shifted = s1_mode ? (s1_data << s1_count) : (s1_data >> s1_count);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= 1'b0;
      s1_count <= '0;
      s1_zero  <= 1'b0;
    end else if (in_accept) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_mode  <= in_mode;
      s1_count <= in_count;
      s1_zero  <= in_zero;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_zero  <= 1'b0;
      out_mode  <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= shifted;
        out_count <= s1_count;
        out_zero  <= s1_zero;
        out_mode  <= s1_mode;
      end
    end
  end

endmodule
